// File: rtl/mux_sw_arbiter.sv
// Packet-level round-robin arbiter driving the one-hot select of the router output mux.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module mux_sw_arbiter #(
  parameter int unsigned      PORTS     = 5,
  parameter int unsigned      TYPEW     = 2,
  parameter logic [TYPEW-1:0] TYPE_NONE = TYPEW'(0),
  parameter logic [TYPEW-1:0] TYPE_HEAD = TYPEW'(1),
  parameter logic [TYPEW-1:0] TYPE_DATA = TYPEW'(2),
  parameter logic [TYPEW-1:0] TYPE_TAIL = TYPEW'(3)
`ifdef ARB_WATCHDOG_EN
  ,
  parameter int unsigned      WDOG_CYC  = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       ivalid,
  input  logic [PORTS*TYPEW-1:0] itype,
  input  logic                   ordy,
  output logic [PORTS-1:0]       sel,
  output logic [PORTS-1:0]       ogrant,
  output logic                   obusy,
  output logic                   oerr
);

  localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_d;
  logic [PW-1:0]    owner, owner_d, rr_ptr, rr_ptr_d, win, owner_inc;
  logic [PORTS-1:0] sel_d, req, flit_vld, stray;
  logic             obusy_d, oerr_d, hd_taken, hd_taken_d;
  logic [TYPEW-1:0] typ [PORTS];

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CW = $clog2(WDOG_CYC + 1);
  logic [CW-1:0] wd_cnt, wd_cnt_d;
`endif

  // Per-port flit classification
  genvar g;
  generate
    for (g = 0; g < PORTS; g++) begin : g_port
      assign typ[g]      = itype[g*TYPEW +: TYPEW];
      assign flit_vld[g] = ivalid[g] && (typ[g] != TYPE_NONE);
      assign req[g]      = ivalid[g] && (typ[g] == TYPE_HEAD);
      assign stray[g]    = ivalid[g] && ((typ[g] == TYPE_DATA) || (typ[g] == TYPE_TAIL));
    end
  endgenerate

  assign owner_inc = (owner == PW'(PORTS - 1)) ? '0 : owner + PW'(1);

  // Circular first-set scan of head requests starting at rr_ptr
  always_comb begin : p_rr_pick
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin : p_state_reg
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      obusy    <= 1'b0;
      oerr     <= 1'b0;
      hd_taken <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      wd_cnt   <= '0;
`endif
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      owner    <= owner_d;
      rr_ptr   <= rr_ptr_d;
      obusy    <= obusy_d;
      oerr     <= oerr_d;
      hd_taken <= hd_taken_d;
`ifdef ARB_WATCHDOG_EN
      wd_cnt   <= wd_cnt_d;
`endif
    end
  end

  always_comb begin : p_next_state
    state_d    = state;
    sel_d      = sel;
    owner_d    = owner;
    rr_ptr_d   = rr_ptr;
    obusy_d    = obusy;
    oerr_d     = 1'b0;
    hd_taken_d = hd_taken;
`ifdef ARB_WATCHDOG_EN
    wd_cnt_d   = wd_cnt;
`endif
    case (state)
      IDLE: begin
        oerr_d = |stray;
        if (|req) begin
          state_d    = BUSY;
          sel_d      = PORTS'(1) << win;
          owner_d    = win;
          obusy_d    = 1'b1;
          hd_taken_d = 1'b0;
`ifdef ARB_WATCHDOG_EN
          wd_cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // The granted head is legitimately still presented until consumed
        if (flit_vld[owner] && (typ[owner] == TYPE_HEAD) && hd_taken) oerr_d = 1'b1;
        if (ogrant[owner]) begin
          hd_taken_d = 1'b1;
          if (typ[owner] == TYPE_TAIL) begin
            state_d  = IDLE;
            sel_d    = '0;
            obusy_d  = 1'b0;
            rr_ptr_d = owner_inc;
          end
        end
`ifdef ARB_WATCHDOG_EN
        if (ogrant[owner]) begin
          wd_cnt_d = '0;
        end else if (!flit_vld[owner]) begin
          if (wd_cnt == CW'(WDOG_CYC - 1)) begin
            state_d  = IDLE;
            sel_d    = '0;
            obusy_d  = 1'b0;
            rr_ptr_d = owner_inc;
            oerr_d   = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt + CW'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : p_outputs
    ogrant = sel & ivalid & {PORTS{ordy}};
  end

endmodule
